// File: rtl/mod_reduce_if.sv
// mod_reduce_if: request/response bundle for the conditional-subtraction stage
interface mod_reduce_if #(parameter int WIDTH = 1027);
    logic             start;
    logic [WIDTH:0]   in_x;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    modport master (output start, in_x, in_m, input result, done, busy);
    modport slave  (input start, in_x, in_m, output result, done, busy);
endinterface

// File: rtl/mod_reduce.sv
// mod_reduce: X mod M for X < 2M via a two-chunk subtract with registered carry
module mod_reduce #(
    parameter int WIDTH = 1027,
    parameter int CHUNK = 514
) (
    input logic         clk,
    input logic         reset,
    mod_reduce_if.slave bus
);
    if (2 * CHUNK != WIDTH + 1) begin : g_bad_chunk
        $error("mod_reduce: 2*CHUNK must equal WIDTH+1");
    end

    typedef enum logic [1:0] {IDLE, SUB_LO, SUB_HI, SELECT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   x_q, x_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic [CHUNK-1:0] op_x, op_m;
    logic             cin;
    logic [CHUNK:0]   sum;

    // One shared CHUNK-bit adder; the high slice sees only the registered carry
    always_comb begin
        op_x = state_q == SUB_HI ? x_q[WIDTH:CHUNK] : x_q[CHUNK-1:0];
        op_m = state_q == SUB_HI ? m_q[WIDTH:CHUNK] : m_q[CHUNK-1:0];
        cin  = state_q == SUB_HI ? c_q : 1'b1;
        sum  = {1'b0, op_x} + {1'b0, ~op_m} + {{CHUNK{1'b0}}, cin};
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        m_d      = m_q;
        diff_d   = diff_q;
        c_d      = c_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.in_x;
                    m_d     = {1'b0, bus.in_m};
                    state_d = SUB_LO;
                end
            end
            SUB_LO: begin
                diff_d[CHUNK-1:0] = sum[CHUNK-1:0];
                c_d               = sum[CHUNK];
                state_d           = SUB_HI;
            end
            SUB_HI: begin
                diff_d[WIDTH:CHUNK] = sum[CHUNK-1:0];
                c_d                 = sum[CHUNK];
                state_d             = SELECT;
            end
            SELECT: begin
                result_d = c_q ? diff_q[WIDTH-1:0] : x_q[WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            m_q      <= '0;
            diff_q   <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            m_q      <= m_d;
            diff_q   <= diff_d;
            c_q      <= c_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = state_q != IDLE;
endmodule

// File: tb/tb_mod_reduce.sv
// tb_mod_reduce: directed vectors with hand-computed expectations for mod_reduce
module tb_mod_reduce;
    localparam int W = 1027;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mod_reduce_if #(.WIDTH(W)) bus ();

    mod_reduce #(.WIDTH(W), .CHUNK(514)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                   tag, got[W-1:W-64], got[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    task automatic run(input string tag, input logic [W:0] x, input logic [W-1:0] m,
                       input logic [W-1:0] exp);
        bus.start = 1'b1;
        bus.in_x  = x;
        bus.in_m  = m;
        tick();
        bus.start = 1'b0;
        bus.in_x  = '1;
        bus.in_m  = '0;
        chk({tag, " busy1"}, W'(bus.busy), W'(1));
        tick();
        chk({tag, " busy2"}, W'(bus.busy), W'(1));
        tick();
        chk({tag, " busy3"}, W'(bus.busy), W'(1));
        chk({tag, " nodone"}, W'(bus.done), W'(0));
        tick();
        chk({tag, " done"}, W'(bus.done), W'(1));
        chk({tag, " idle"}, W'(bus.busy), W'(0));
        chk({tag, " result"}, bus.result, exp);
        tick();
        chk({tag, " done_drop"}, W'(bus.done), W'(0));
        chk({tag, " hold"}, bus.result, exp);
    endtask

    initial begin
        logic [W:0]   x;
        logic [W-1:0] m;
        logic [W-1:0] e;
        bus.start = 1'b0;
        bus.in_x  = '0;
        bus.in_m  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst result", bus.result, '0);
        chk("rst done", W'(bus.done), W'(0));
        chk("rst busy", W'(bus.busy), W'(0));

        run("basic", W'(10), W'(7), W'(3));
        run("nosub", W'(5), W'(7), W'(5));
        run("equal", 'h1234, 'h1234, '0);

        x = '0;
        x[514] = 1'b1;
        e = '0;
        for (int i = 0; i < 514; i++) e[i] = 1'b1;
        run("chunk_borrow", x, W'(1), e);

        x = '1;
        x[1] = 1'b0;
        m = '1;
        e = '1;
        e[0] = 1'b0;
        run("carry_bit", x, m, e);

        run("m_zero", W'(85), '0, W'(85));
        run("over_range", W'(20), W'(7), W'(13));

        bus.start = 1'b1;
        bus.in_x  = W'(10);
        bus.in_m  = W'(7);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("held done%0d", i), W'(bus.done), W'(i % 4 == 3));
            if (i % 4 == 3) chk($sformatf("held result%0d", i), bus.result, W'(3));
        end
        bus.start = 1'b0;
        tick();
        chk("held stop", W'(bus.busy), W'(0));

        bus.start = 1'b1;
        bus.in_x  = W'(5);
        bus.in_m  = W'(7);
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.in_x  = W'(100);
        bus.in_m  = W'(1);
        tick();
        bus.start = 1'b0;
        tick();
        chk("ign done", W'(bus.done), W'(1));
        chk("ign result", bus.result, W'(5));
        tick();
        chk("ign norestart", W'(bus.busy), W'(0));
        chk("ign done_drop", W'(bus.done), W'(0));

        bus.start = 1'b1;
        bus.in_x  = W'(10);
        bus.in_m  = W'(7);
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", W'(bus.busy), W'(0));
        chk("midrst done", W'(bus.done), W'(0));
        chk("midrst result", bus.result, '0);
        tick();
        chk("midrst stays", W'(bus.busy), W'(0));

        run("after_rst", W'(10), W'(7), W'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mod_reduce.md
Name: mod_reduce

Overview:
- Final conditional-subtraction stage placed directly downstream of the 2-chunk 1027-bit adder/subtractor.
- Consumes the adder's 1028-bit sum X (carry bit included) and the modulus M.
- Outputs X mod M for X < 2·M, i.e. X−M when X ≥ M, else X.
- Computes X−M internally over two CHUNK-bit cycles with a registered borrow, the same chunking scheme as the adder, so synthesis still sees a single CHUNK-bit adder.

Parameters:
- WIDTH, 1027, operand/modulus width in bits.
- CHUNK, 514, adder slice width. Requirement: 2·CHUNK = WIDTH+1; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- in_x  input  WIDTH+1  value to reduce; bit WIDTH is the adder carry-out
- in_m  input  WIDTH  modulus M
- result  output  WIDTH  reduced value; registered
- done  output  1  one-cycle pulse, result valid
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=1 at a clk edge):
  - state←IDLE; result←0; done←0; busy←0.
  - Internal X/M/difference/borrow registers←0.
  - Reset overrides every other input in the same cycle, including mid-operation.
- Clock and reset: single clock domain; synchronous active-high reset.
- FSM states: IDLE, SUB_LO, SUB_HI, SELECT.
- IDLE:
  - On start=1: capture X←in_x and M←{1'b0,in_m} (WIDTH+1 bits); go to SUB_LO.
  - Otherwise stay in IDLE.
  - in_x/in_m are not sampled after the capture edge and may change freely.
- SUB_LO:
  - D_lo = X[CHUNK-1:0] + ~M[CHUNK-1:0] + 1.
  - Store D[CHUNK-1:0] and carry c0; go to SUB_HI.
- SUB_HI:
  - D_hi = X[2CHUNK-1:CHUNK] + ~M[2CHUNK-1:CHUNK] + c0.
  - Store D[2CHUNK-1:CHUNK] and final carry c1; go to SELECT.
- SELECT:
  - c1=1 (X ≥ M): result←D[WIDTH-1:0].
  - c1=0 (X < M): result←X[WIDTH-1:0].
  - done←1 for exactly this one edge; return to IDLE.
- Latency: start sampled at edge 0 → done=1 and result valid after edge 3 (three cycles after acceptance).
- Throughput: one reduction per 4 cycles. A start asserted in the same cycle done is high is sampled in IDLE on the following edge only if still held.
- result holds its value until the next SELECT or reset; done is 0 in all other cycles.
- start while busy=1 is ignored: no restart, no queueing, no effect on the running operation.
- Range rule: the input contract is X < 2·M. For X ≥ 2·M the output is X−M truncated to WIDTH bits, with no error flag.
- X = M gives result 0.
- M = 0: c1=1 always, so result = X[WIDTH-1:0].
- Carry propagation across the chunk boundary uses only the registered c0; there is no combinational path from the low chunk to the high chunk.
- busy = (state ≠ IDLE), decoded from the state register.

Test Plan:
- Basic subtract: X=10, M=7, start pulse → done pulse 3 cycles after acceptance, result=3; busy high for exactly 3 cycles.
- No subtract: X=5, M=7 → result=5.
- Equality: X=M=0x1234 → result=0.
- Inter-chunk borrow: X=2^514, M=1 → result=2^514−1 (all ones in bits 513:0, zeros above).
- Carry bit used: M=2^1027−1, X=2^1028−3 → result=2^1027−2.
- Control edge cases:
  - start held high through a whole operation: exactly one done per 4 cycles, results correct.
  - start pulsed during SUB_HI: ignored.
  - reset asserted during SUB_HI: next cycle state=IDLE, result=0, done=0, busy=0.
  - A following X=10, M=7 request then completes with result=3.
